adam_mem_arbiter: RTL and testbench

- Shares one single-port memory macro (adam_mem / instr_rom style req/addr/we/be/wdata/rdata interface) between NO_REQS requesters, e.g. an adam_axil_to_mem bridge and a debug/boot loader.
- Round-robin arbitration with a same-cycle grant.
- Fixed-latency read-data return, tagged back to the issuing requester.
- Sits between the bridges and the memory in the FPGA top level, in the memory's clock domain.

---
 rtl/adam_mem_arb_pkg.sv | 20 ++
 rtl/adam_rr_sel.sv | 46 ++++
 rtl/adam_mem_arbiter.sv | 108 ++++++++++
 tb/tb_adam_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_mem_arb_pkg.sv
// Shared types and helpers for the memory arbiter and its round-robin selector.
// Pipeline tags are sized for the largest supported requester count.
package adam_mem_arb_pkg;

    localparam int MAX_RD_LATENCY = 4;
    localparam int MAX_REQS       = 8;
    localparam int ID_MAX_W       = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } rd_tag_t;

    function automatic logic [ID_MAX_W-1:0] next_idx(input logic [ID_MAX_W-1:0] ptr,
                                                     input int unsigned n);
        if (32'(ptr) + 1 >= n) return '0;
        return ptr + ID_MAX_W'(1);
    endfunction

endpackage

// File: rtl/adam_rr_sel.sv
// Combinational round-robin selector: first asserted request at or above prio_ptr,
// wrapping modulo N. Returns a one-hot grant and its binary index.
module adam_rr_sel #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] prio_ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W:0] N_W = (PTR_W+1)'(N);

    logic [N-1:0]     rot;
    logic [PTR_W-1:0] off;
    logic [PTR_W:0]   sum;
    logic             found;

    // Rotating the doubled vector puts the priority position at bit 0.
    assign rot = N'({req, req} >> prio_ptr);

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = PTR_W'(k);
            end
        end
    end

    always_comb begin
        sum = {1'b0, prio_ptr} + {1'b0, off};
        idx = (sum >= N_W) ? PTR_W'(sum - N_W) : PTR_W'(sum);
    end

    always_comb begin
        gnt = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = found && (idx == PTR_W'(j));
        end
    end

endmodule

// File: rtl/adam_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NO_REQS requesters,
// with same-cycle grant and fixed-latency tagged read-data return.
module adam_mem_arbiter
    import adam_mem_arb_pkg::*;
#(
    parameter int NO_REQS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NO_REQS-1:0]             slv_req,
    output logic [NO_REQS-1:0]             slv_gnt,
    input  logic [NO_REQS*ADDR_WIDTH-1:0]  slv_addr,
    input  logic [NO_REQS-1:0]             slv_we,
    input  logic [NO_REQS*DATA_WIDTH/8-1:0] slv_be,
    input  logic [NO_REQS*DATA_WIDTH-1:0]  slv_wdata,
    output logic [DATA_WIDTH-1:0]          slv_rdata,
    output logic [NO_REQS-1:0]             slv_rvalid,
    output logic                           mst_req,
    output logic [ADDR_WIDTH-1:0]          mst_addr,
    output logic                           mst_we,
    output logic [DATA_WIDTH/8-1:0]        mst_be,
    output logic [DATA_WIDTH-1:0]          mst_wdata,
    input  logic [DATA_WIDTH-1:0]          mst_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W      = (NO_REQS > 1) ? $clog2(NO_REQS) : 1;

    if (NO_REQS < 1 || NO_REQS > MAX_REQS || RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_param_check
        $error("adam_mem_arbiter: NO_REQS or RD_LATENCY out of range");
    end

    logic [PTR_W-1:0]   prio_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [NO_REQS-1:0] sel_gnt;
    rd_tag_t            pipe [RD_LATENCY];

    adam_rr_sel #(
        .N     (NO_REQS),
        .PTR_W (PTR_W)
    ) u_rr_sel (
        .req      (slv_req),
        .prio_ptr (prio_ptr),
        .gnt      (sel_gnt),
        .idx      (gnt_idx)
    );

    assign slv_gnt = rstn ? sel_gnt : '0;
    // Any pending request is granted this cycle, so mst_req doubles as "accepted".
    assign mst_req = rstn & (|slv_req);

    always_comb begin
        mst_addr  = '0;
        mst_we    = 1'b0;
        mst_be    = '0;
        mst_wdata = '0;
        for (int i = 0; i < NO_REQS; i++) begin
            if (slv_gnt[i]) begin
                mst_addr  = slv_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mst_we    = slv_we[i];
                mst_be    = slv_be[i*STRB_WIDTH +: STRB_WIDTH];
                mst_wdata = slv_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio_ptr <= '0;
        end else if (mst_req) begin
            prio_ptr <= PTR_W'(next_idx(ID_MAX_W'(gnt_idx), NO_REQS));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0].valid <= mst_req && !mst_we;
            pipe[0].id    <= ID_MAX_W'(gnt_idx);
            for (int k = 1; k < RD_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    always_comb begin
        slv_rvalid = '0;
        for (int i = 0; i < NO_REQS; i++) begin
            slv_rvalid[i] = rstn && pipe[RD_LATENCY-1].valid
                            && (pipe[RD_LATENCY-1].id == ID_MAX_W'(i));
        end
    end

    assign slv_rdata = mst_rdata;

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk) $onehot0(slv_gnt));
    a_gnt_has_req: assert property (@(posedge clk) (slv_gnt & ~slv_req) == '0);
    a_req_has_gnt: assert property (@(posedge clk) mst_req |-> (|slv_gnt));
`endif

endmodule

// File: tb/tb_adam_mem_arbiter.sv
// Directed bench: a 2-requester/latency-1 arbiter and a 3-requester/latency-3 arbiter,
// each in front of a small behavioural memory.
module tb_adam_mem_arbiter;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    // 2 requesters, RD_LATENCY = 1
    logic [1:0]  req2;
    logic [1:0]  gnt2;
    logic [63:0] addr2;
    logic [1:0]  we2;
    logic [7:0]  be2;
    logic [63:0] wdata2;
    logic [31:0] rdata2;
    logic [1:0]  rvalid2;
    logic        mreq2;
    logic [31:0] maddr2;
    logic        mwe2;
    logic [3:0]  mbe2;
    logic [31:0] mwdata2;
    logic [31:0] mrdata2;
    logic [31:0] mem2 [64];

    // 3 requesters, RD_LATENCY = 3
    logic [2:0]  req3;
    logic [2:0]  gnt3;
    logic [95:0] addr3;
    logic [2:0]  we3;
    logic [11:0] be3;
    logic [95:0] wdata3;
    logic [31:0] rdata3;
    logic [2:0]  rvalid3;
    logic        mreq3;
    logic [31:0] maddr3;
    logic        mwe3;
    logic [3:0]  mbe3;
    logic [31:0] mwdata3;
    logic [31:0] r3_0, r3_1, r3_2;
    logic [31:0] mem3 [64];

    adam_mem_arbiter #(.NO_REQS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(1)) dut2 (
        .clk(clk), .rstn(rstn),
        .slv_req(req2), .slv_gnt(gnt2), .slv_addr(addr2), .slv_we(we2), .slv_be(be2),
        .slv_wdata(wdata2), .slv_rdata(rdata2), .slv_rvalid(rvalid2),
        .mst_req(mreq2), .mst_addr(maddr2), .mst_we(mwe2), .mst_be(mbe2),
        .mst_wdata(mwdata2), .mst_rdata(mrdata2)
    );

    adam_mem_arbiter #(.NO_REQS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RD_LATENCY(3)) dut3 (
        .clk(clk), .rstn(rstn),
        .slv_req(req3), .slv_gnt(gnt3), .slv_addr(addr3), .slv_we(we3), .slv_be(be3),
        .slv_wdata(wdata3), .slv_rdata(rdata3), .slv_rvalid(rvalid3),
        .mst_req(mreq3), .mst_addr(maddr3), .mst_we(mwe3), .mst_be(mbe3),
        .mst_wdata(mwdata3), .mst_rdata(r3_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memories; contents reload to A000_0000 + word index during reset.
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) mem2[i] <= 32'hA000_0000 + 32'(i);
        end else if (mreq2) begin
            if (mwe2) begin
                for (int b = 0; b < 4; b++)
                    if (mbe2[b]) mem2[maddr2[7:2]][b*8 +: 8] <= mwdata2[b*8 +: 8];
            end else begin
                mrdata2 <= mem2[maddr2[7:2]];
            end
        end
    end

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 32'hA000_0000 + 32'(i);
        end else if (mreq3 && !mwe3) begin
            r3_0 <= mem3[maddr3[7:2]];
        end
        r3_1 <= r3_0;
        r3_2 <= r3_1;
    end

    task automatic test_reset();
        rstn   = 1'b0;
        req2   = 2'b11;
        addr2  = {32'h0000_0024, 32'h0000_0020};
        we2    = 2'b01;
        be2    = 8'hFF;
        wdata2 = {32'h1234_5678, 32'h9ABC_DEF0};
        req3   = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_cmp++; if (gnt2 !== 2'b00) begin n_err++; $display("FAIL reset_gnt2 cyc %0d: got %b want 00", c, gnt2); end
            n_cmp++; if (mreq2 !== 1'b0) begin n_err++; $display("FAIL reset_mreq2 cyc %0d: got %b want 0", c, mreq2); end
            n_cmp++; if (rvalid2 !== 2'b00) begin n_err++; $display("FAIL reset_rvalid2 cyc %0d: got %b want 00", c, rvalid2); end
            n_cmp++; if (maddr2 !== 32'h0 || mwdata2 !== 32'h0 || mwe2 !== 1'b0 || mbe2 !== 4'h0) begin
                n_err++; $display("FAIL reset_mux2 cyc %0d: got addr %h wdata %h we %b be %h want all 0", c, maddr2, mwdata2, mwe2, mbe2);
            end
            n_cmp++; if (gnt3 !== 3'b000) begin n_err++; $display("FAIL reset_gnt3 cyc %0d: got %b want 000", c, gnt3); end
        end
        @(negedge clk);
        rstn = 1'b1;
        we2  = 2'b00;
        #1;
        n_cmp++; if (gnt2 !== 2'b01) begin n_err++; $display("FAIL reset_first_gnt2: got %b want 01", gnt2); end
        n_cmp++; if (mreq2 !== 1'b1) begin n_err++; $display("FAIL reset_first_mreq2: got %b want 1", mreq2); end
        n_cmp++; if (gnt3 !== 3'b001) begin n_err++; $display("FAIL reset_first_gnt3: got %b want 001", gnt3); end
        // Withdraw before the edge so nothing is accepted and the pointers stay at 0.
        req2 = 2'b00;
        req3 = 3'b000;
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g;
        logic [1:0]  prev_g;
        logic [31:0] exp_a;
        req2   = 2'b00;
        prev_g = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                addr2 = {32'h0000_0024, 32'h0000_0020};
                we2   = 2'b00;
                req2  = 2'b11;
            end
            if (c == 4) req2 = 2'b00;
            #1;
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_a = (c % 2 == 0) ? 32'h20 : 32'h24;
            if (c < 4) begin
                n_cmp++; if (gnt2 !== exp_g) begin n_err++; $display("FAIL contention_gnt cyc %0d: got %b want %b", c, gnt2, exp_g); end
                n_cmp++; if (maddr2 !== exp_a) begin n_err++; $display("FAIL contention_addr cyc %0d: got %h want %h", c, maddr2, exp_a); end
            end
            if (c > 0) begin
                n_cmp++; if (rvalid2 !== prev_g) begin n_err++; $display("FAIL contention_rvalid cyc %0d: got %b want %b", c, rvalid2, prev_g); end
                n_cmp++; if (rdata2 !== ((prev_g == 2'b01) ? 32'hA000_0008 : 32'hA000_0009)) begin
                    n_err++; $display("FAIL contention_rdata cyc %0d: got %h want %h", c, rdata2,
                                      (prev_g == 2'b01) ? 32'hA000_0008 : 32'hA000_0009);
                end
            end
            prev_g = exp_g;
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req2   = 2'b10;
        we2    = 2'b10;
        addr2  = {32'h0000_0010, 32'h0};
        be2    = 8'hF0;
        wdata2 = {32'hDEAD_BEEF, 32'h0};
        #1;
        n_cmp++; if (gnt2 !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", gnt2); end
        n_cmp++; if (mwe2 !== 1'b1 || mwdata2 !== 32'hDEAD_BEEF || mbe2 !== 4'hF || maddr2 !== 32'h10) begin
            n_err++; $display("FAIL wr_mux: got we %b data %h be %h addr %h want 1 deadbeef f 10", mwe2, mwdata2, mbe2, maddr2);
        end
        @(negedge clk);
        we2 = 2'b00;
        #1;
        n_cmp++; if (rvalid2 !== 2'b00) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 00", rvalid2); end
        n_cmp++; if (gnt2 !== 2'b10) begin n_err++; $display("FAIL rd_back2back_gnt: got %b want 10", gnt2); end
        @(negedge clk);
        req2 = 2'b00;
        #1;
        n_cmp++; if (rvalid2 !== 2'b10) begin n_err++; $display("FAIL rd_rvalid: got %b want 10", rvalid2); end
        n_cmp++; if (rdata2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", rdata2); end
    endtask

    task automatic test_byte_enable();
        @(negedge clk);
        req2   = 2'b01;
        we2    = 2'b01;
        addr2  = {32'h0, 32'h0000_0014};
        be2    = 8'h0F;
        wdata2 = {32'h0, 32'h1122_3344};
        @(negedge clk);
        be2    = 8'h02;
        wdata2 = {32'h0, 32'h0000_AA00};
        #1;
        n_cmp++; if (mbe2 !== 4'b0010) begin n_err++; $display("FAIL be_mux: got %b want 0010", mbe2); end
        @(negedge clk);
        we2 = 2'b00;
        #1;
        n_cmp++; if (rvalid2 !== 2'b00) begin n_err++; $display("FAIL be_no_rvalid: got %b want 00", rvalid2); end
        @(negedge clk);
        req2 = 2'b00;
        #1;
        n_cmp++; if (rvalid2 !== 2'b01) begin n_err++; $display("FAIL be_rvalid: got %b want 01", rvalid2); end
        n_cmp++; if (rdata2 !== 32'h1122_AA44) begin n_err++; $display("FAIL be_rdata: got %h want 1122aa44", rdata2); end
    endtask

    task automatic test_latency3();
        logic [2:0]  exp_v;
        logic [31:0] exp_d;
        addr3 = {32'h0000_000C, 32'h0000_0008, 32'h0000_0004};
        we3   = 3'b000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            // Each requester withdraws once it has been granted.
            req3 = (c == 0) ? 3'b111 : (c == 1) ? 3'b110 : (c == 2) ? 3'b100 : 3'b000;
            #1;
            if (c < 3) begin
                n_cmp++; if (gnt3 !== (3'b001 << c)) begin n_err++; $display("FAIL lat3_gnt cyc %0d: got %b want %b", c, gnt3, 3'b001 << c); end
            end
            exp_v = (c >= 3) ? (3'b001 << (c - 3)) : 3'b000;
            n_cmp++; if (rvalid3 !== exp_v) begin n_err++; $display("FAIL lat3_rvalid cyc %0d: got %b want %b", c, rvalid3, exp_v); end
            if (c >= 3) begin
                exp_d = 32'hA000_0000 + 32'(c - 2);
                n_cmp++; if (rdata3 !== exp_d) begin n_err++; $display("FAIL lat3_rdata cyc %0d: got %h want %h", c, rdata3, exp_d); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        req2  = 2'b01;
        we2   = 2'b00;
        addr2 = {32'h0, 32'h0000_0020};
        req3  = 3'b001;
        addr3 = {64'h0, 32'h0000_0004};
        #1;
        n_cmp++; if (gnt3 !== 3'b001) begin n_err++; $display("FAIL midrst_gnt3: got %b want 001", gnt3); end
        @(negedge clk);
        rstn = 1'b0;
        req2 = 2'b00;
        req3 = 3'b000;
        #1;
        n_cmp++; if (rvalid2 !== 2'b00) begin n_err++; $display("FAIL midrst_rvalid2_in_reset: got %b want 00", rvalid2); end
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                req2 = 2'b11;
                req3 = 3'b111;
            end
            #1;
            n_cmp++; if (rvalid2 !== 2'b00) begin n_err++; $display("FAIL midrst_rvalid2 cyc %0d: got %b want 00", c, rvalid2); end
            n_cmp++; if (rvalid3 !== 3'b000) begin n_err++; $display("FAIL midrst_rvalid3 cyc %0d: got %b want 000", c, rvalid3); end
            if (c < 2) @(negedge clk);
        end
        n_cmp++; if (gnt2 !== 2'b01) begin n_err++; $display("FAIL midrst_ptr2: got %b want 01", gnt2); end
        n_cmp++; if (gnt3 !== 3'b001) begin n_err++; $display("FAIL midrst_ptr3: got %b want 001", gnt3); end
        req2 = 2'b00;
        req3 = 3'b000;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rstn   = 1'b0;
        req2   = '0; addr2 = '0; we2 = '0; be2 = '0; wdata2 = '0;
        req3   = '0; addr3 = '0; we3 = '0; be3 = 12'hFFF; wdata3 = '0;
        test_reset();
        test_contention();
        test_write_read();
        test_byte_enable();
        test_latency3();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
